mdu_seq: RTL and testbench

- Multi-cycle sequencer for the RV64M multiply/divide operations that the single-cycle execute ALU does not implement.
- Sits in the execute stage beside the ALU. The pipeline issues one op via a valid/ready handshake and stalls until the result handshake completes.
- Uses one shared iterative datapath: shift-add multiply and restoring divide, one bit per cycle, with sign pre/post-correction.

---
 rtl/mdu_seq.sv | 217 +++++++++++++++++++++
 tb/tb_mdu_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M multiply/divide unit beside the execute ALU.
// One shared shift-add multiply / restoring divide datapath, one bit per cycle.
module mdu_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    // state | meaning
    // IDLE  | waiting for an op, in_ready high unless flushing
    // CALC  | one multiplier/quotient bit per cycle, counter counts down
    // FIXUP | sign correction and result select
    // DONE  | result valid, waiting for out_ready
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                negr_q, negr_d;
    logic [XLEN-1:0]     res_q, res_d;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic f_w(input logic [3:0] o);
        return (o >= 4'd8) && (o <= 4'd12);
    endfunction

    function automatic logic f_div(input logic [3:0] o);
        return ((o >= 4'd4) && (o <= 4'd7)) || ((o >= 4'd9) && (o <= 4'd12));
    endfunction

    function automatic logic f_rem(input logic [3:0] o);
        return (o == 4'd6) || (o == 4'd7) || (o == 4'd11) || (o == 4'd12);
    endfunction

    function automatic logic f_s1(input logic [3:0] o);
        return (o == 4'd0) || (o == 4'd1) || (o == 4'd2) || (o == 4'd4) ||
               (o == 4'd6) || (o == 4'd9) || (o == 4'd11);
    endfunction

    function automatic logic f_s2(input logic [3:0] o);
        return (o == 4'd0) || (o == 4'd1) || (o == 4'd4) || (o == 4'd6) ||
               (o == 4'd9) || (o == 4'd11);
    endfunction

    logic            acc_w, acc_div, acc_rem, acc_s1, acc_s2, acc_ill;
    logic            div_zero, div_ovf, special, neg1, neg2;
    logic [XLEN-1:0] x1, x2, m1, m2, dvd, sp_res;

    // Accept-side decode: extend operands, take magnitudes, detect special cases.
    always_comb begin
        acc_w   = f_w(op);
        acc_div = f_div(op);
        acc_rem = f_rem(op);
        acc_s1  = f_s1(op);
        acc_s2  = f_s2(op);
        acc_ill = (op >= 4'd13);
        x1 = src1;
        x2 = src2;
        if (acc_w) begin
            x1 = acc_s1 ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]};
            x2 = acc_s2 ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]};
        end
        neg1 = acc_s1 & x1[XLEN-1];
        neg2 = acc_s2 & x2[XLEN-1];
        m1   = neg1 ? (~x1 + 1'b1) : x1;
        m2   = neg2 ? (~x2 + 1'b1) : x2;
        dvd  = acc_w ? sext32(src1[31:0]) : src1;
        div_zero = acc_div && (x2 == '0);
        if (acc_w)
            div_ovf = acc_div && acc_s1 && (src1[31:0] == 32'h8000_0000) &&
                      (src2[31:0] == 32'hFFFF_FFFF);
        else
            div_ovf = acc_div && acc_s1 && (src1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (src2 == '1);
        special = acc_ill || div_zero || div_ovf;
        if (acc_ill)
            sp_res = '0;
        else if (div_zero)
            sp_res = acc_rem ? dvd : '1;
        else
            sp_res = acc_rem ? '0 : dvd;
    end

    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_sub;
    logic              rem_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, dv, fix_res;

    always_comb begin
        rem_sh  = {acc_q[XLEN-1:0], b_q[XLEN-1]};
        rem_ge  = (rem_sh >= {1'b0, a_q[XLEN-1:0]});
        rem_sub = rem_sh[XLEN-1:0] - a_q[XLEN-1:0];
        prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo     = neg_q ? (~b_q + 1'b1) : b_q;
        rmd     = negr_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        dv      = f_rem(op_q) ? rmd : quo;
        if (op_q == 4'd0)
            fix_res = prod[XLEN-1:0];
        else if (op_q <= 4'd3)
            fix_res = prod[2*XLEN-1:XLEN];
        else if (op_q == 4'd8)
            fix_res = sext32(prod[31:0]);
        else
            fix_res = f_w(op_q) ? sext32(dv[31:0]) : dv;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d = op;
                        if (special) begin
                            res_d   = sp_res;
                            state_d = DONE;
                        end else begin
                            acc_d   = '0;
                            a_d     = {{XLEN{1'b0}}, (acc_div ? m2 : m1)};
                            // W divides run 32 steps, so the dividend sits in the top half.
                            if (acc_div)
                                b_d = acc_w ? {m1[31:0], {(XLEN-32){1'b0}}} : m1;
                            else
                                b_d = m2;
                            neg_d   = neg1 ^ neg2;
                            negr_d  = neg1;
                            cnt_d   = acc_w ? 7'd32 : 7'd64;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (f_div(op_q)) begin
                        acc_d = {{XLEN{1'b0}}, (rem_ge ? rem_sub : rem_sh[XLEN-1:0])};
                        b_d   = {b_q[XLEN-2:0], rem_ge};
                    end else begin
                        if (b_q[0])
                            acc_d = acc_q + a_q;
                        a_d = a_q << 1;
                        b_d = b_q >> 1;
                    end
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        state_d = FIXUP;
                end
                FIXUP: begin
                    res_d   = fix_res;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: hand-computed results, latencies, backpressure,
// flush and mid-op reset.
module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] src1 = 64'd0;
    logic [63:0] src2 = 64'd0;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op away from the clock edge, accept it, then scramble inputs.
    task automatic issue(input string tag, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b);
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op   = 4'($urandom);
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
    endtask

    task automatic wait_result(input string tag, input logic [63:0] exp, input int lat);
        int n = 1;
        logic rdy_seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " in_ready while busy"}, {63'd0, rdy_seen}, 64'd0);
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " retire"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
        issue(tag, o, a, b);
        wait_result(tag, exp, lat);
        retire(tag);
    endtask

    initial begin
        logic bad_v, bad_r, bad_i, seen;

        #12;
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset result", result, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("idle in_ready", {63'd0, in_ready}, 64'd1);

        run("MUL 7*-3", 4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run("MULHU", 4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run("MULH", 4'd1, '1, '1, 64'd0, 66);
        run("MULHSU", 4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("DIV -7/2", 4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run("REM -7,2", 4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run("DIVU 100/7", 4'd5, 64'd100, 64'd7, 64'd14, 66);
        run("REMU 100/7", 4'd7, 64'd100, 64'd7, 64'd2, 66);
        run("DIVU 5/0", 4'd5, 64'd5, 64'd0, '1, 1);
        run("REMU 5/0", 4'd7, 64'd5, 64'd0, 64'd5, 1);
        run("DIV ovf", 4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run("REM ovf", 4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run("DIVUW", 4'd10, 64'h1234_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34);
        run("DIVW ovf", 4'd9, 64'h5555_5555_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1);
        run("MULW", 4'd8, 64'h1_0000, 64'h1_0000, 64'd0, 34);
        run("REMW -7,2", 4'd11, 64'hABCD_0000_FFFF_FFF9, 64'h7777_0000_0000_0002,
            64'hFFFF_FFFF_FFFF_FFFF, 34);
        run("illegal op", 4'd14, 64'd9, 64'd3, 64'd0, 1);

        // Backpressure: hold out_ready low in DONE.
        issue("MUL bp", 4'd0, 64'd5, 64'd6);
        wait_result("MUL bp", 64'd30, 66);
        bad_v = 1'b0; bad_r = 1'b0; bad_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1) bad_v = 1'b1;
            if (result !== 64'd30) bad_r = 1'b1;
            if (in_ready !== 1'b0) bad_i = 1'b1;
        end
        check("bp out_valid held", {63'd0, bad_v}, 64'd0);
        check("bp result stable", {63'd0, bad_r}, 64'd0);
        check("bp in_ready low", {63'd0, bad_i}, 64'd0);
        retire("MUL bp");

        // Flush during CALC.
        issue("MUL flush", 4'd0, '1, '1);
        repeat (19) @(posedge clk);
        #1;
        check("flush busy in CALC", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        #1;
        check("flush in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush no out_valid", {63'd0, seen}, 64'd0);
        check("flush result held", result, 64'd30);
        run("MUL 3*4", 4'd0, 64'd3, 64'd4, 64'd12, 66);

        // Async reset mid-CALC.
        issue("DIVU rst", 4'd5, 64'd1000, 64'd3);
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst result", result, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("rst no stale result", {63'd0, seen}, 64'd0);
        check("rst result zero", result, 64'd0);
        run("DIV 100/-7", 4'd4, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 66);
        run("REM 100,-7", 4'd6, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
